// File: rtl/rs424_uart_rx.sv
// RS-424 asynchronous frame deserializer: oversampled start detect, LSB-first data, stop check,
// one-entry valid/ready holding register. Define RS424_RX_PARITY_EN to add an even-parity bit.
module rs424_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_bit,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef RS424_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    logic                 sync1_q, rx_s_q;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 stop_q, stop_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;
    logic                 parity_bad;

`ifdef RS424_RX_PARITY_EN
    logic parity_q, parity_d;
    assign parity_bad = (^shreg_q) ^ parity_q;
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        valid_d = valid_q & ~data_ready;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        ovr_d   = ovr_q;
`ifdef RS424_RX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef RS424_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef RS424_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d    = '0;
                    parity_d = rx_s_q;
                    state_d  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Stop bit is latched first; the outcome is resolved one cycle later.
                if (done_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (!stop_q) begin
                        ferr_d = 1'b1;
                    end else if (parity_bad) begin
                        perr_d = 1'b1;
                    end else if (!valid_q || data_ready) begin
                        dout_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (cnt_q == CNT_FULL) begin
                    stop_d = rx_s_q;
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef RS424_RX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            sync1_q <= rx_bit;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
`ifdef RS424_RX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);
endmodule

// File: doc/rs424_uart_rx.md
# rs424_uart_rx

Asynchronous frame deserializer that sits directly downstream of the RS-424 line receiver. It consumes the receiver's recovered serial bit (`op_bit`) and locates start bits by oversampling. It assembles LSB-first data words, checks the stop bit, and hands each completed word to the host through a one-entry valid/ready holding register.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; even, ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, 5..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_bit`  in  1  serial line from the receiver's `op_bit`; idle = 1.
- `data_out`  out  DATA_BITS  received word; valid while `data_valid` = 1.
- `data_valid`  out  1  holding register full.
- `data_ready`  in  1  host accepts the word when `data_valid` = 1 and `data_ready` = 1.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (always 0 without the macro).
- `overrun`  out  1  sticky; a good frame completed while the holding register was full.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Input path: `rx_bit` passes through a 2-flop synchronizer into `rx_s`. Both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP. Bit counter: `$clog2(CLKS_PER_BIT)` bits. Data index: 0..DATA_BITS-1.
- IDLE: on `rx_s` = 0, go to START and clear the counter. The entry cycle is S.
- START: at counter = CLKS_PER_BIT/2-1, sample `rx_s`:
  - 0: go to DATA and clear the counter.
  - 1: false start; return to IDLE with no output.
- DATA: sample at each counter = CLKS_PER_BIT-1. Shift the sample in at bit [index], LSB first. After bit DATA_BITS-1, go to PARITY (macro) or STOP.
- PARITY: sample at counter = CLKS_PER_BIT-1, then go to STOP.
- STOP: sample at counter = CLKS_PER_BIT-1, then return to IDLE. Outcomes:
  - Stop = 0: pulse `frame_err`; discard the word.
  - Stop = 1 and parity bad: pulse `parity_err`; discard the word.
  - Good frame, holding register empty or being read in the same cycle: load `data_out` and set `data_valid`.
  - Good frame, holding register full and not being read: set `overrun`; drop the new word; keep the old one.
- IDLE after a frame error re-arms only when `rx_s` = 0. A held-low break therefore restarts START immediately and raises `frame_err` again each frame period.
- `data_valid` clears on the cycle after the handshake (valid & ready). `data_out` holds its value until the next load.
- `overrun` clears only on `rst`.
- Reset mid-frame: the FSM goes to IDLE, the partial word is lost, and all flags clear.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `frame_err` = 0, `parity_err` = 0, `overrun` = 0, `busy` = 0. Synchronizer flops = 1, FSM = IDLE.
- START is entered 2 cycles after `rx_bit` first reads 0 (synchronizer depth).
- Sample instants, relative to S (P = 1 with the macro, else 0):
  - Start bit: S + CLKS_PER_BIT/2.
  - Data bit k: S + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop bit: S + CLKS_PER_BIT/2 + (DATA_BITS+P+1)·CLKS_PER_BIT.
- `data_valid` rises, or `frame_err`/`parity_err` pulses, exactly 1 cycle after the stop sample.
- `busy` falls in that same cycle.
- Back-to-back frames: a start bit arriving immediately after a stop bit is accepted.

## Configuration
- `RS424_RX_PARITY_EN` defined:
  - PARITY state is present, and one even-parity bit follows the data bits.
  - Even parity means the data bits plus the parity bit contain an even number of 1s.
  - A mismatch pulses `parity_err` and discards the word.
  - Frame length is 1 + DATA_BITS + 1 + 1 bits.
- Undefined:
  - No PARITY state; `parity_err` is tied to 0.
  - Frame length is 1 + DATA_BITS + 1 bits.

## Test plan
- Defaults, no macro, `data_ready` = 1. Send frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) → `data_out` = 0xA5 and `data_valid` = 1 for one cycle at S+153.
- Glitch test: drive `rx_bit` low for 4 cycles while idle → START aborts at S+8, `busy` falls, no `data_valid`, no `frame_err`.
- Frame error: send 0x3C with stop bit = 0 → `frame_err` pulses 1 cycle at S+153, `data_valid` stays 0. Then send 0x3C with a valid stop → `data_valid` = 1, `data_out` = 0x3C.
- Overrun: hold `data_ready` = 0 and send 0x11 then 0x22 → `data_out` = 0x11, `overrun` = 1. Then pulse `data_ready` → `data_valid` = 0, `overrun` stays 1.
- Macro defined: send 0x03 with parity bit 1 → `parity_err` pulses, no `data_valid`. Send 0x03 with parity bit 0 → `data_out` = 0x03 at S+169.
- Assert `rst` for 1 cycle during bit 4 of a frame → all outputs 0 next cycle. The next full frame 0x5A is received correctly.
